random_byte_gen: RTL

- Fabric-side responder for the Nios random-number PIO link.
- Consumes the 32-bit seed word and the 8-bit system-control word driven by the processor.
- Returns an 8-bit random byte on the processor's random input PIO, plus ready/busy status.
- Core is a 32-bit Galois LFSR stepped one bit per clock; software requests bytes with a toggle handshake.

---
 rtl/random_gen_pkg.sv | 22 ++
 rtl/random_byte_gen.sv | 112 +++++++++++
 2 files changed

// File: rtl/random_gen_pkg.sv
// Shared constants, state encoding and the Galois LFSR step function for the
// random-byte responder; the step function also serves bench-side models.
package random_gen_pkg;

  localparam logic [31:0] POLY_DEF = 32'h8020_0003;
  localparam logic [31:0] SEED_DEF = 32'hACE1_2468;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_SEED = 1;
  localparam int CTRL_REQ  = 2;
  localparam int CTRL_FREE = 3;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  // Returns {next_lfsr, out_bit}.
  function automatic logic [32:0] lfsr_step(input logic [31:0] lfsr, input logic [31:0] poly);
    logic out;
    out = lfsr[0];
    return {(lfsr >> 1) ^ (out ? poly : 32'h0), out};
  endfunction

endpackage

// File: rtl/random_byte_gen.sv
// Nios random PIO responder: 32-bit Galois LFSR, one step per clock, bytes
// requested with a toggle handshake on ctrl_i[2].
module random_byte_gen
  import random_gen_pkg::*;
#(
  parameter logic [31:0] POLY         = POLY_DEF,
  parameter logic [31:0] SEED_DEFAULT = SEED_DEF
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [7:0]  ctrl_i,
  input  logic [31:0] seed_i,
  output logic [7:0]  random_o,
  output logic        ready_o,
  output logic        busy_o
);

  state_e      state, state_n;
  logic [31:0] lfsr, lfsr_n;
  logic [2:0]  cnt, cnt_n;
  logic [6:0]  sr, sr_n;
  logic [7:0]  rnd_n;
  logic        ready_n, busy_n, pending, pend_n;
  logic [2:1]  ctrl_q;
  logic [32:0] step;
  logic        en, free, req, seed_edge;
  logic        unused_ctrl;

  assign unused_ctrl = ^ctrl_i[7:4];
  assign en        = ctrl_i[CTRL_EN];
  assign free      = ctrl_i[CTRL_FREE];
  assign req       = ctrl_i[CTRL_REQ] ^ ctrl_q[CTRL_REQ];
  assign seed_edge = ctrl_i[CTRL_SEED] & ~ctrl_q[CTRL_SEED];
  assign step      = lfsr_step(lfsr, POLY);

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    sr_n    = sr;
    rnd_n   = random_o;
    ready_n = ready_o;
    busy_n  = busy_o;
    pend_n  = pending;
    if (seed_edge) begin
      // Seed load pre-empts everything, including an in-flight byte.
      lfsr_n  = (seed_i == 32'h0) ? SEED_DEFAULT : seed_i;
      state_n = IDLE;
      cnt_n   = '0;
      ready_n = 1'b0;
      busy_n  = 1'b0;
      pend_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && en) begin
            state_n = SHIFT;
            cnt_n   = '0;
            ready_n = 1'b0;
            busy_n  = 1'b1;
          end else if (en && free) begin
            lfsr_n = step[32:1];
          end
        end
        SHIFT: begin
          lfsr_n  = step[32:1];
          sr_n    = {step[0], sr[6:1]};
          cnt_n   = cnt + 3'd1;
          ready_n = 1'b0;
          pend_n  = en & (pending | req);
          if (cnt == 3'd7) begin
            // Bits 0..6 sit in sr (LSB-first), this step supplies bit 7.
            rnd_n   = {step[0], sr};
            ready_n = 1'b1;
            cnt_n   = '0;
            if (pend_n) begin
              pend_n = 1'b0;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      lfsr     <= SEED_DEFAULT;
      cnt      <= '0;
      sr       <= '0;
      random_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
      pending  <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state    <= state_n;
      lfsr     <= lfsr_n;
      cnt      <= cnt_n;
      sr       <= sr_n;
      random_o <= rnd_n;
      ready_o  <= ready_n;
      busy_o   <= busy_n;
      pending  <= pend_n;
      ctrl_q   <= ctrl_i[2:1];
    end
  end

endmodule
